// File: rtl/master_port.sv
// master_port: master-side serial bus interface toward the system-bus arbiter.
// Takes one parallel read/write command, requests the bus, sends the serial
// slave-select sequence, shifts address and write data out (or read data in),
// and reports done/error back to the core.
//
// Optional feature: define MASTER_PORT_TIMEOUT_EN to bound the REQ and WAIT
// states by TIMEOUT cycles (aborting with error). Without it both states wait
// indefinitely and the TIMEOUT parameter is unused.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start
// S_REQ   | request raised, waiting for grant
// S_SEL   | serial slave select: marker 1, then slave_id[0..2]
// S_ADDR  | address out on bus_out, LSB first
// S_WAIT  | waiting for slave_ready
// S_WDATA | write data out on bus_out, LSB first
// S_RDATA | read data in from bus_in, LSB first
// S_DONE  | completion cycle; done pulses on the following edge
module master_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  rw,
    input  logic [2:0]            slave_id,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  request,
    input  logic                  grant,
    output logic                  slave_select,
    output logic                  bus_out,
    output logic                  bus_valid,
    output logic                  bus_mode,
    input  logic                  bus_in,
    input  logic                  slave_ready
);

    localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW   = $clog2(MAXW) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_SEL, S_ADDR, S_WAIT, S_WDATA, S_RDATA, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  rw_q;
    logic [2:0]            id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] shadow_q;
    logic                  err_set;
    logic                  to_hit;

    logic                  busy_d, request_d, ss_d, bus_out_d, bus_valid_d, bus_mode_d;
    logic [3:0]            sel_vec;
    logic [ADDR_WIDTH-1:0] addr_vec;
    logic [DATA_WIDTH-1:0] data_vec;

`ifdef MASTER_PORT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_cnt_q;

    // Wait-cycle counter for REQ and WAIT, restarted on every state change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_q <= '0;
        end else if (state_d != state_q) begin
            to_cnt_q <= '0;
        end else if (state_q == S_REQ || state_q == S_WAIT) begin
            to_cnt_q <= to_cnt_q + TW'(1);
        end
    end

    // The TIMEOUT-th wait cycle is the last one tolerated.
    assign to_hit = (to_cnt_q == TW'(TIMEOUT - 1));
`else
    assign to_hit = 1'b0;
`endif

    // Next-state logic; losing grant anywhere between SEL and RDATA aborts.
    always_comb begin
        state_d = state_q;
        err_set = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_d = S_REQ;
            S_REQ: begin
                if (grant) begin
                    state_d = S_SEL;
                end else if (to_hit) begin
                    state_d = S_DONE;
                    err_set = 1'b1;
                end
            end
            S_SEL: begin
                if (!grant) begin
                    state_d = S_DONE;
                    err_set = 1'b1;
                end else if (cnt_q == CW'(3)) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (!grant) begin
                    state_d = S_DONE;
                    err_set = 1'b1;
                end else if (cnt_q == CW'(ADDR_WIDTH - 1)) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!grant) begin
                    state_d = S_DONE;
                    err_set = 1'b1;
                end else if (slave_ready) begin
                    state_d = rw_q ? S_WDATA : S_RDATA;
                end else if (to_hit) begin
                    state_d = S_DONE;
                    err_set = 1'b1;
                end
            end
            S_WDATA, S_RDATA: begin
                if (!grant) begin
                    state_d = S_DONE;
                    err_set = 1'b1;
                end else if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bit counter and next values of the registered outputs, derived from
    // the state being entered so every output is a clean flop.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == S_SEL || state_q == S_ADDR ||
                     state_q == S_WDATA || state_q == S_RDATA) begin
            cnt_d = cnt_q + CW'(1);
        end

        sel_vec  = {id_q, 1'b1} >> cnt_d;
        addr_vec = addr_q >> cnt_d;
        data_vec = wdata_q >> cnt_d;

        busy_d      = (state_d != S_IDLE);
        ss_d        = (state_d == S_SEL) && sel_vec[0];
        bus_out_d   = 1'b0;
        if (state_d == S_ADDR)  bus_out_d = addr_vec[0];
        if (state_d == S_WDATA) bus_out_d = data_vec[0];
        bus_valid_d = (state_d == S_ADDR) || (state_d == S_WDATA);
        bus_mode_d  = rw_q && (state_d == S_SEL || state_d == S_ADDR || state_d == S_WAIT ||
                               state_d == S_WDATA || state_d == S_RDATA);
        // A grant timeout in REQ keeps request up until the done pulse.
        request_d   = (state_d == S_REQ || state_d == S_SEL || state_d == S_ADDR ||
                       state_d == S_WAIT || state_d == S_WDATA || state_d == S_RDATA) ||
                      (state_d == S_DONE && state_q == S_REQ);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            request      <= 1'b0;
            slave_select <= 1'b0;
            bus_out      <= 1'b0;
            bus_valid    <= 1'b0;
            bus_mode     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            busy         <= busy_d;
            done         <= (state_q == S_DONE);
            request      <= request_d;
            slave_select <= ss_d;
            bus_out      <= bus_out_d;
            bus_valid    <= bus_valid_d;
            bus_mode     <= bus_mode_d;
        end
    end

    // Command capture, error flag, read shadow shift and rdata update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rw_q     <= 1'b0;
            id_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            shadow_q <= '0;
            error    <= 1'b0;
            rdata    <= '0;
        end else begin
            if (state_q == S_IDLE && start) begin
                rw_q    <= rw;
                id_q    <= slave_id;
                addr_q  <= addr;
                wdata_q <= wdata;
                error   <= 1'b0;
            end else if (err_set) begin
                error <= 1'b1;
            end
            if (state_q == S_RDATA) begin
                shadow_q <= {bus_in, shadow_q[DATA_WIDTH-1:1]};
            end
            if (state_q == S_DONE && !error && !rw_q) begin
                rdata <= shadow_q;
            end
        end
    end

endmodule
